// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/sub: one CHUNK-bit ripple slice reused over WIDTH/CHUNK passes,
// carry held in a register between passes, start/busy/done handshake.

module csa_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   Sum,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic             carry_q;
  logic [31:0]      base;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic [CHUNK:0]   c;
  logic             accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(N - 1));
  assign base   = 32'(cnt) * CHUNK;
  assign a_ch   = a_q[base +: CHUNK];
  assign b_ch   = b_q[base +: CHUNK];
  assign c[0]   = carry_q;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    csa_fa u_fa (
      .a (a_ch[i]),
      .b (b_ch[i]),
      .ci(c[i]),
      .s (s_ch[i]),
      .co(c[i+1])
    );
  end

  always_comb begin
    acc_nxt = acc;
    acc_nxt[base +: CHUNK] = s_ch;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded in at capture time: B is stored inverted, carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      Sum      <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_q     <= sub ? ~B : B;
      carry_q <= sub ? 1'b1 : Cin;
      cnt     <= '0;
    end else if (state == BUSY) begin
      acc     <= acc_nxt;
      carry_q <= c[CHUNK];
      cnt     <= last ? '0 : cnt + 1'b1;
      if (last) begin
        Sum      <= {c[CHUNK], acc_nxt};
        overflow <= c[CHUNK] ^ c[CHUNK-1];
      end
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Four configurations driven by shared stimulus, checked each cycle against an
// arithmetic reference, plus hand-computed results for the 16-bit instances.

module tb_chunk_serial_adder;
  localparam int WS [4] = '{16, 16, 16, 32};
  localparam int NS [4] = '{4, 16, 1, 4};

  logic        clk = 1'b0;
  logic        rst, start, Cin, sub;
  logic [31:0] A, B;
  logic [3:0]  busy_v, done_v, ovf_v;
  logic [16:0] s0, s1, s2;
  logic [32:0] s3;
  logic [32:0] sum_v [4];
  logic        armed = 1'b0;
  int          errors = 0, checks = 0;

  int          ph [4];
  logic [32:0] es [4], ps [4];
  logic        eo [4], po [4];

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .sub(sub),
    .busy(busy_v[0]), .done(done_v[0]), .Sum(s0), .overflow(ovf_v[0]));
  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .sub(sub),
    .busy(busy_v[1]), .done(done_v[1]), .Sum(s1), .overflow(ovf_v[1]));
  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .sub(sub),
    .busy(busy_v[2]), .done(done_v[2]), .Sum(s2), .overflow(ovf_v[2]));
  chunk_serial_adder #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin), .sub(sub),
    .busy(busy_v[3]), .done(done_v[3]), .Sum(s3), .overflow(ovf_v[3]));

  assign sum_v[0] = {16'b0, s0};
  assign sum_v[1] = {16'b0, s1};
  assign sum_v[2] = {16'b0, s2};
  assign sum_v[3] = s3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result: {overflow, carry+sum} from plain integer arithmetic.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic s);
    logic [63:0] m, aa, bb, r;
    logic        o;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'b0, a} & m;
    bb = {32'b0, (s ? ~b : b)} & m;
    r  = aa + bb + (s ? 64'd1 : {63'b0, ci});
    o  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    r  = r & ((m << 1) | 64'd1);
    return {o, r[32:0]};
  endfunction

  // Model: ph = -1 idle, 0..N-1 cycles into busy, N = done cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        ph[i] <= -1;
        es[i] <= '0;
        eo[i] <= 1'b0;
      end else if ((ph[i] < 0 || ph[i] == NS[i]) && start) begin
        ph[i] <= 0;
        {po[i], ps[i]} <= ref_op(WS[i], A, B, Cin, sub);
      end else if (ph[i] >= 0 && ph[i] < NS[i]) begin
        ph[i] <= ph[i] + 1;
        if (ph[i] == NS[i] - 1) begin
          es[i] <= ps[i];
          eo[i] <= po[i];
        end
      end else begin
        ph[i] <= -1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("busy[%0d]", i), 64'(busy_v[i]), 64'(ph[i] >= 0 && ph[i] < NS[i]));
        chk($sformatf("done[%0d]", i), 64'(done_v[i]), 64'(ph[i] == NS[i]));
        chk($sformatf("sum[%0d]", i), 64'(sum_v[i]), 64'(es[i]));
        chk($sformatf("ovf[%0d]", i), 64'(ovf_v[i]), 64'(eo[i]));
      end
    end
  end

  task automatic lit16(input string nm, input logic [16:0] s, input logic o);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_sum[%0d]", nm, i), 64'(sum_v[i]), 64'(s));
      chk($sformatf("%s_ovf[%0d]", nm, i), 64'(ovf_v[i]), 64'(o));
    end
  endtask

  // One operation; operands scrambled after acceptance; measures busy length and done latency.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
    int nb [4];
    int dk [4];
    @(negedge clk);
    A = a; B = b; Cin = ci; sub = s; start = 1'b1;
    for (int i = 0; i < 4; i++) begin nb[i] = 0; dk[i] = -1; end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
        if (busy_v[i]) nb[i]++;
        if (done_v[i] && dk[i] < 0) dk[i] = k;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("busy_len[%0d]", i), 64'(nb[i]), 64'(NS[i]));
      chk($sformatf("done_lat[%0d]", i), 64'(dk[i]), 64'(NS[i]));
    end
  endtask

  initial begin
    int   seen;
    logic got;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    armed = 1'b1;
    rst   = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy_v), 64'd0);
    chk("rst_done", 64'(done_v), 64'd0);
    lit16("rst", 17'h00000, 1'b0);
    repeat (3) @(negedge clk);
    lit16("idle", 17'h00000, 1'b0);

    op(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0); lit16("ripple", 17'h10000, 1'b0);
    op(32'h00001234, 32'h00001111, 1'b1, 1'b0); lit16("cin",    17'h02346, 1'b0);
    op(32'h00007FFF, 32'h00000001, 1'b0, 1'b0); lit16("ovf",    17'h08000, 1'b1);
    op(32'h00000005, 32'h00000007, 1'b0, 1'b1); lit16("sub",    17'h0FFFE, 1'b0);
    op(32'h00008000, 32'h00000001, 1'b0, 1'b1); lit16("subovf", 17'h17FFF, 1'b1);
    op(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0);
    op(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1);

    // start and operand changes mid-BUSY must be ignored
    @(negedge clk); A = 32'h1000; B = 32'h0234; Cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0; A = 32'hFFFF; B = 32'hFFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midbusy_sum0", 64'(sum_v[0]), 64'h1234);
    chk("midbusy_sum1", 64'(sum_v[1]), 64'h1234);
    chk("midbusy_sum3", 64'(sum_v[3]), 64'h1234);
    chk("midbusy_sum2", 64'(sum_v[2]), 64'h1FFFE);

    // back-to-back acceptance in the DONE cycle
    @(negedge clk); A = 32'h0010; B = 32'h0020; start = 1'b1;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (done_v[0]) got = 1'b1;
    end
    chk("b2b_done_seen", 64'(got), 64'd1);
    chk("b2b_first_sum", 64'(sum_v[0]), 64'h30);
    A = 32'h0001; B = 32'h0002; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("b2b_no_gap", 64'(busy_v[0]), 64'd1);
    repeat (20) @(negedge clk);
    chk("b2b_sum", 64'(sum_v[0]), 64'h3);

    // reset in the second BUSY cycle aborts the operation
    @(negedge clk); A = 32'h00FF; B = 32'h0F00; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 64'(busy_v[0]), 64'd0);
    chk("abort_sum", 64'(sum_v[0]), 64'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    op(32'h00000100, 32'h00000200, 1'b0, 1'b0); lit16("after_abort", 17'h00300, 1'b0);

    // random traffic with occasional reset
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      A = $urandom; B = $urandom; Cin = 1'($urandom); sub = 1'($urandom);
      start = ($urandom_range(0, 2) == 0);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
